// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared SDRAM/cache constants
// State encodings for the cache front end and the cache-to-SDRAM port.
package sdram_pkg;

  localparam int BURSTLEN = 8;

  typedef logic [1:0] cache_state_t;
  localparam cache_state_t C_IDLE   = 2'd0;
  localparam cache_state_t C_LOOKUP = 2'd1;
  localparam cache_state_t C_REFILL = 2'd2;
  localparam cache_state_t C_WRITE  = 2'd3;

  typedef logic [2:0] port_state_t;
  localparam port_state_t P_IDLE      = 3'd0;
  localparam port_state_t P_RDCMD     = 3'd1;
  localparam port_state_t P_RDCOLLECT = 3'd2;
  localparam port_state_t P_RDSTREAM  = 3'd3;
  localparam port_state_t P_WRCMD     = 3'd4;
  localparam port_state_t P_WRHI      = 3'd5;
  localparam port_state_t P_WRLO      = 3'd6;
  localparam port_state_t P_WRDONE    = 3'd7;

endpackage

// File: rtl/cache_sdram_port_if.sv
// rtl/cache_sdram_port_if.sv - cache-side and controller-side buses
// master drives requests, slave answers them.
interface cache_bus_if;
  logic        c_req;
  logic        c_rw;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;
  logic [3:0]  c_bytesel;
  logic        c_fill;
  logic [15:0] c_rdata;
  logic        c_wack;
  logic        busy;

  modport master (output c_req, c_rw, c_addr, c_wdata, c_bytesel,
                  input  c_fill, c_rdata, c_wack, busy);
  modport slave  (input  c_req, c_rw, c_addr, c_wdata, c_bytesel,
                  output c_fill, c_rdata, c_wack, busy);
endinterface

interface ctl_bus_if #(parameter int ADDRBITS = 25);
  logic                ctl_req;
  logic                ctl_ack;
  logic                ctl_rw;
  logic [ADDRBITS-1:0] ctl_addr;
  logic [15:0]         ctl_wdata;
  logic [1:0]          ctl_dqm;
  logic                ctl_wnext;
  logic                ctl_rvalid;
  logic [15:0]         ctl_rdata;

  modport master (output ctl_req, ctl_rw, ctl_addr, ctl_wdata, ctl_dqm,
                  input  ctl_ack, ctl_wnext, ctl_rvalid, ctl_rdata);
  modport slave  (input  ctl_req, ctl_rw, ctl_addr, ctl_wdata, ctl_dqm,
                  output ctl_ack, ctl_wnext, ctl_rvalid, ctl_rdata);
endinterface

// File: rtl/cache_sdram_port_line_buffer8x16.sv
// rtl/cache_sdram_port_line_buffer8x16.sv - 8x16 register line buffer
// One write port, one asynchronous read port; contents need no reset.
module line_buffer8x16 (
  input  logic        clk,
  input  logic        we,
  input  logic [2:0]  waddr,
  input  logic [15:0] wdata,
  input  logic [2:0]  raddr,
  output logic [15:0] rdata
);

  logic [15:0] mem [8];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cache_sdram_port.sv
// rtl/cache_sdram_port.sv - cache line-fill / word-write port to SDRAM controller
// Reads collect a full burst before streaming it gap-free; writes go out as two halfwords.
module cache_sdram_port
  import sdram_pkg::*;
#(
  parameter int CTL_ADDRBITS = 25,
  parameter int BURSTLEN     = sdram_pkg::BURSTLEN
) (
  input  logic     clk,
  input  logic     reset,
  cache_bus_if.slave cache,
  ctl_bus_if.master  ctl
);

  localparam logic [2:0] LAST = 3'(BURSTLEN - 1);

  port_state_t                state, state_nxt;
  logic [2:0]                 cnt;
  logic [CTL_ADDRBITS-1:2]    addr_q;
  logic [31:0]                wdata_q;
  logic [3:0]                 bsel_q;
  logic                       need_low;
  logic                       wack_sent;
  logic                       accept;
  logic                       buf_we;
  logic [15:0]                buf_rdata;
  logic                       unused_addr;

  assign unused_addr = ^{cache.c_addr[31:CTL_ADDRBITS], cache.c_addr[1:0]};

  // A finished read leaves need_low set so a still-held request is not replayed.
  assign accept = cache.c_req && !need_low;
  assign buf_we = (state == P_RDCOLLECT) && ctl.ctl_rvalid;

  line_buffer8x16 u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (cnt),
    .wdata (ctl.ctl_rdata),
    .raddr (cnt),
    .rdata (buf_rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= P_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt       <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      bsel_q    <= '0;
      need_low  <= 1'b0;
      wack_sent <= 1'b0;
    end else begin
      if (state == P_IDLE && accept) begin
        addr_q  <= cache.c_addr[CTL_ADDRBITS-1:2];
        wdata_q <= cache.c_wdata;
        bsel_q  <= cache.c_bytesel;
      end
      // cnt wraps to 0 after the 8th halfword, ready to index the stream.
      if (buf_we || state == P_RDSTREAM) cnt <= cnt + 3'd1;
      if (state == P_RDSTREAM && cnt == LAST)         need_low <= 1'b1;
      else if (state == P_IDLE && !cache.c_req)       need_low <= 1'b0;
      wack_sent <= (state == P_WRDONE);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      P_IDLE:      if (accept) state_nxt = cache.c_rw ? P_RDCMD : P_WRCMD;
      P_RDCMD:     if (ctl.ctl_ack) state_nxt = P_RDCOLLECT;
      P_RDCOLLECT: if (ctl.ctl_rvalid && cnt == LAST) state_nxt = P_RDSTREAM;
      P_RDSTREAM:  if (cnt == LAST) state_nxt = P_IDLE;
      P_WRCMD:     if (ctl.ctl_ack) state_nxt = P_WRHI;
      P_WRHI:      if (ctl.ctl_wnext) state_nxt = P_WRLO;
      P_WRLO:      if (ctl.ctl_wnext) state_nxt = P_WRDONE;
      P_WRDONE:    if (!cache.c_req) state_nxt = P_IDLE;
      default:     state_nxt = P_IDLE;
    endcase
  end

  always_comb begin
    ctl.ctl_req   = 1'b0;
    ctl.ctl_rw    = 1'b0;
    ctl.ctl_addr  = '0;
    ctl.ctl_wdata = '0;
    ctl.ctl_dqm   = 2'b11;
    cache.c_fill  = 1'b0;
    cache.c_rdata = '0;
    cache.c_wack  = 1'b0;
    cache.busy    = 1'b0;
    if (reset) begin
      cache.busy = (state != P_IDLE);
      case (state)
        P_RDCMD: begin
          ctl.ctl_req  = 1'b1;
          ctl.ctl_rw   = 1'b1;
          ctl.ctl_addr = {addr_q, 2'b00};
        end
        P_RDSTREAM: begin
          cache.c_rdata = buf_rdata;
          cache.c_fill  = (cnt == 3'd0);
        end
        P_WRCMD: begin
          ctl.ctl_req  = 1'b1;
          ctl.ctl_addr = {addr_q, 2'b00};
        end
        P_WRHI: begin
          ctl.ctl_wdata = wdata_q[31:16];
          ctl.ctl_dqm   = ~bsel_q[3:2];
        end
        P_WRLO: begin
          ctl.ctl_wdata = wdata_q[15:0];
          ctl.ctl_dqm   = ~bsel_q[1:0];
        end
        P_WRDONE: cache.c_wack = !wack_sent;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/cache_sdram_port.md
CACHE_SDRAM_PORT -- requirements
Module: cache_sdram_port

Interface
REQ-001 SHALL have parameter CTL_ADDRBITS, default 25, the byte-address width presented to the SDRAM controller.
REQ-002 SHALL have parameter BURSTLEN, default 8, the number of halfwords per read burst; only 8 is supported.
REQ-003 clk  in  1  clock; all logic on posedge.
REQ-004 reset  in  1  synchronous, active-low.
REQ-005 c_req  in  1  cache request; level, held until serviced.
REQ-006 c_rw  in  1  1=read line, 0=write word.
REQ-007 c_addr  in  32  cache byte address.
REQ-008 c_wdata  in  32  write data.
REQ-009 c_bytesel  in  4  byte enables, bit3=[31:24].
REQ-010 c_fill  out  1  one-cycle pulse; first returned halfword is valid on c_rdata this cycle.
REQ-011 c_rdata  out  16  returned halfword stream.
REQ-012 c_wack  out  1  one-cycle write-complete pulse.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 ctl_req  out  1  controller command request.
REQ-015 ctl_ack  in  1  command accepted.
REQ-016 ctl_rw  out  1  1=read burst, 0=write.
REQ-017 ctl_addr  out  CTL_ADDRBITS  command byte address.
REQ-018 ctl_wdata  out  16  write halfword.
REQ-019 ctl_dqm  out  2  active-high byte mask.
REQ-020 ctl_wnext  in  1  controller consumed ctl_wdata.
REQ-021 ctl_rvalid  in  1  ctl_rdata valid; gaps are allowed.
REQ-022 ctl_rdata  in  16  read halfword.

Function
REQ-023 States SHALL be IDLE, RDCMD, RDCOLLECT, RDSTREAM, WRCMD, WRHI, WRLO, WRDONE.
REQ-024 In IDLE with c_req=1, the block SHALL latch c_addr, c_wdata and c_bytesel, and go to RDCMD if c_rw=1, else WRCMD.
REQ-025 In RDCMD, ctl_req=1, ctl_rw=1, ctl_addr={c_addr[CTL_ADDRBITS-1:4], c_addr[3:2], 2'b00} (critical word first, controller wraps within the 16-byte line); on ctl_ack the block SHALL go to RDCOLLECT with ctl_req=0 the next cycle.
REQ-026 RDCOLLECT SHALL store each ctl_rvalid halfword in an 8x16 buffer at index cnt, with a 3-bit cnt; after the 8th halfword it SHALL go to RDSTREAM.
REQ-027 RDSTREAM SHALL output buffer[0..7] on c_rdata on 8 consecutive cycles with no gaps, pulse c_fill on the first of these, then return to IDLE; the order is high half then low half of each word, as delivered.
REQ-028 Read latency: c_fill SHALL occur exactly 1 cycle after the cycle the 8th ctl_rvalid is sampled.
REQ-029 In WRCMD, ctl_req=1, ctl_rw=0, ctl_addr={latched addr[CTL_ADDRBITS-1:2], 2'b00}; on ctl_ack the block SHALL go to WRHI.
REQ-030 In WRHI, ctl_wdata=wdata[31:16] and ctl_dqm=~bytesel[3:2]; on ctl_wnext the block SHALL go to WRLO.
REQ-031 In WRLO, ctl_wdata=wdata[15:0] and ctl_dqm=~bytesel[1:0]; on ctl_wnext the block SHALL go to WRDONE.
REQ-032 WRDONE SHALL pulse c_wack for one cycle, then return to IDLE only once c_req=0 (no re-trigger on a held request).
REQ-033 After the read stream, the block SHALL likewise not accept a new request until c_req has been seen low at least once in IDLE.
REQ-034 The block SHALL ignore ctl_rvalid outside RDCOLLECT; ctl_wnext outside WRHI/WRLO; ctl_ack outside RDCMD/WRCMD.
REQ-035 c_req falling mid-transaction SHALL NOT abort it; the transaction SHALL complete and all outputs SHALL be generated normally.
REQ-036 bytesel=0000 SHALL still issue both halfword writes with ctl_dqm=11.

Reset
REQ-037 While reset=0, the block SHALL hold state IDLE, clear cnt, and drive ctl_req=0, c_fill=0, c_wack=0, busy=0, ctl_dqm=11, ctl_wdata=0, c_rdata=0.
REQ-038 Reset mid-burst SHALL abandon the transaction with no c_fill or c_wack afterwards; the request-seen-low interlock SHALL clear.

Structure
REQ-039 State encodings and BURSTLEN SHALL be localparams in the shared sdram_pkg, alongside the cache's state constants.
REQ-040 The 8x16 line buffer SHALL be a sub-module line_buffer8x16 (registers, 1 write port, 1 read port).

Verification
REQ-041 Scenario: read at 0x00001238, controller returns 0x1111..0x8888 with 2 random gaps -> ctl_addr=0x1238; c_fill 1 cycle after the last rvalid; c_rdata 0x1111..0x8888 contiguous.
REQ-042 Scenario: write 0xDEADBEEF to 0x40, bytesel=1111 -> ctl_wdata 0xDEAD then 0xBEEF, dqm 00/00, one c_wack.
REQ-043 Scenario: write with bytesel=0010 -> dqm 11 then 01.
REQ-044 Scenario: c_req held high after c_wack -> no second ctl_req until c_req drops.
REQ-045 Scenario: reset=0 after the 4th rvalid -> no c_fill; the next read completes normally.
REQ-046 Scenario: spurious ctl_rvalid/ctl_wnext pulses in IDLE -> no state change, no output pulses.
